stall_ctrl: RTL
===============

# stall_ctrl

Hazard and stall controller for the five-stage pipeline. It holds the F/D register and PC (stall), bubbles the D/E register (clear), and tracks the multiply/divide unit's busy window with an internal down-counter. Issue is sequenced from the D stage against the E and M stage producers. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles loaded for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles loaded for div/divu.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `D_A1`, `D_A2` input, 5 bits each: rs and rt of the D-stage instruction.
- `D_Tuse_rs`, `D_Tuse_rt` input, 2 bits each: cycles until the operand is needed (0..2); 3 means not used.
- `D_md_use` input, 1 bit: the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `E_A3` input, 5 bits, and `E_Tnew` input, 2 bits: E-stage destination register and cycles until its result exists (0..2).
- `M_A3` input, 5 bits, and `M_Tnew` input, 2 bits: same for the M stage (0..1).
- `E_md_start` input, 1 bit: a mult/div is in E this cycle; one-cycle pulse.
- `E_md_is_div` input, 1 bit: qualifies `E_md_start`; 1 selects div, 0 selects mult.
- `D_Stall` output, 1 bit: hold the F/D register and PC.
- `E_Clear` output, 1 bit: load a bubble into the D/E register.
- `md_busy` output, 1 bit: the mult/div unit is occupied.
- `md_count` output, 4 bits: remaining busy cycles.
- `stall_cycles` output, 32 bits: saturating count of cycles with `D_Stall` asserted.

## Operation
- Register stall for rs: `D_A1 != 0` and `D_A1 == E_A3` and `D_Tuse_rs < E_Tnew`; or the same test against M (`M_A3`, `M_Tnew`). The same rule applies to rt with `D_A2` and `D_Tuse_rt`.
- Tuse = 3 never stalls, because Tnew is at most 2.
- Register $0 never stalls.
- Mult/div stall: `D_md_use & md_busy`.
- `md_busy = E_md_start | (md_count != 0)`. It is combinational, so the issue cycle itself blocks the next md instruction.
- `D_Stall` is the OR of the rs, rt and mult/div stall terms. `E_Clear` equals `D_Stall`, so every stall cycle inserts exactly one bubble.
- Counter, priority order:
  - `E_md_start`: load `DIV_CYCLES` or `MULT_CYCLES`, selected by `E_md_is_div`.
  - Otherwise, if nonzero: decrement.
  - Otherwise: hold at 0.
- `E_md_start` while already busy should not occur, because D stalls all md instructions while busy. If it does occur, the counter reloads and the new operation wins.
- `stall_cycles` increments every cycle `D_Stall` is 1. It saturates at 0xFFFFFFFF and does not wrap.

## Timing
- All stall and clear outputs are combinational from the current inputs and `md_count`, with zero latency.
- While `reset` is high: `D_Stall`, `E_Clear` and `md_busy` are forced to 0.
- On the reset edge: `md_count` and `stall_cycles` clear to 0. A reset in the middle of a busy window aborts it immediately.
- Mult issued in E at cycle t:
  - `md_count` is 5 at t+1 and reaches 0 at t+6.
  - `md_busy` is high for cycles t..t+5 (6 cycles).
  - An md instruction waiting in D proceeds at t+6.
- Div issued at cycle t: `md_busy` is high for t..t+10 (11 cycles).
- Simultaneous register hazard and md hazard: a single stall; `stall_cycles` increments by 1.

## Structure
- `def.v` holds:
  - Tuse/Tnew encodings (`TUSE_NONE` = 2'd3).
  - Default `MULT_CYCLES`/`DIV_CYCLES` values.
- Sub-module `md_busy_timer`: the load/decrement counter and `md_busy` generation.
- `stall_ctrl` holds the hazard comparators and the stall counter, and instantiates `md_busy_timer`.

## Test plan
- D add with rs=$8, Tuse 1; E lw writing $8 with E_Tnew=2 → `D_Stall`=`E_Clear`=1 for that cycle. With E_Tnew=1 instead → 0.
- D_A1=0 and E_A3=0 with E_Tnew=2 → no stall. D_Tuse_rs=3 against a matching E_A3 → no stall.
- `E_md_start`=1 with `E_md_is_div`=0 at cycle t, and `D_md_use` held at 1 → `D_Stall` high for exactly 6 cycles; `md_count` sequence 5,4,3,2,1,0.
- Div start → `md_busy` for 11 cycles. A `reset` pulse at the 4th busy cycle → `md_count`=0 and `md_busy`=0 on the next cycle.
- Register hazard and md busy together for 3 cycles → `stall_cycles` increases by 3. Preload near 0xFFFFFFFF and keep stalling → holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and defaults for the hazard/stall controller.
//   TUSE_NONE      : Tuse code meaning "operand not read"
//   MULT_CYCLES_DEF: default busy window for mult/multu
//   DIV_CYCLES_DEF : default busy window for div/divu
//   reg_hazard()   : one operand against one producer stage
package stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE      = 2'd3;
  localparam int         MULT_CYCLES_DEF = 5;
  localparam int         DIV_CYCLES_DEF  = 10;

  // Stall when the producer's result arrives later than the consumer needs it.
  // Tuse = 3 can never be below a legal Tnew (max 2), so unused operands drop out.
  function automatic logic reg_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                      input logic [4:0] a3, input logic [1:0] tnew);
    return (a != 5'd0) && (a == a3) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// Mult/div busy window: loads a cycle count on issue, counts down to zero.
//   clk, reset      : clock, synchronous active-high reset
//   start, is_div   : md op in E this cycle; selects div vs mult length
//   busy            : unit occupied (includes the issue cycle itself)
//   count           : remaining busy cycles after the issue cycle
module md_busy_timer
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_div,
  output logic       busy,
  output logic [3:0] count
);

  always_ff @(posedge clk) begin
    if (reset)               count <= 4'd0;
    else if (start)          count <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);  // reload wins
    else if (count != 4'd0)  count <= count - 4'd1;
  end

  // Combinational so the issue cycle already blocks the next md instruction.
  assign busy = ~reset & (start | (count != 4'd0));

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
//   D_A1/D_A2, D_Tuse_rs/D_Tuse_rt : D-stage sources and their need times
//   E_A3/E_Tnew, M_A3/M_Tnew       : producer destinations and ready times
//   D_md_use                       : D instruction uses the mult/div unit
//   E_md_start, E_md_is_div        : mult/div issue pulse in E
//   D_Stall / E_Clear              : hold F/D + PC / bubble into D/E
//   md_busy, md_count              : mult/div occupancy
//   stall_cycles                   : saturating count of stalled cycles
// STALL_CNT_W sets the width of the stall counter (zero-extended to 32 bits).
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        D_Stall,
  output logic        E_Clear,
  output logic        md_busy,
  output logic [3:0]  md_count,
  output logic [31:0] stall_cycles
);

  logic rs_stall, rt_stall, md_stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (E_md_start),
    .is_div(E_md_is_div),
    .busy  (md_busy),
    .count (md_count)
  );

  assign rs_stall = reg_hazard(D_A1, D_Tuse_rs, E_A3, E_Tnew) |
                    reg_hazard(D_A1, D_Tuse_rs, M_A3, M_Tnew);
  assign rt_stall = reg_hazard(D_A2, D_Tuse_rt, E_A3, E_Tnew) |
                    reg_hazard(D_A2, D_Tuse_rt, M_A3, M_Tnew);
  assign md_stall = D_md_use & md_busy;

  // One stall cycle == one bubble, regardless of how many terms fire.
  assign D_Stall = ~reset & (rs_stall | rt_stall | md_stall);
  assign E_Clear = D_Stall;

  always_ff @(posedge clk) begin
    if (reset)                               stall_cnt <= '0;
    else if (D_Stall && (stall_cnt != '1))   stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  assign stall_cycles = 32'(stall_cnt);

endmodule
